// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out link bundle for serial_word_receiver.
// The master side drives the serial stream, p_ready and err_clr; the slave side is the receiver.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             s_din;
    logic             s_valid;
    logic             s_sync;
    logic [WIDTH-1:0] p_dout;
    logic             p_valid;
    logic             p_ready;
    logic             par_err;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;

    modport master (
        output s_din, s_valid, s_sync, p_ready, err_clr,
        input  p_dout, p_valid, par_err, overrun, frame_err
    );

    modport slave (
        input  s_din, s_valid, s_sync, p_ready, err_clr,
        output p_dout, p_valid, par_err, overrun, frame_err
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Assembles WIDTH-bit words from a qualified serial stream and presents them on a valid/ready port.
// Optional feature macro SER_PARITY_EN: a trailing even-parity bit per word, checked into par_err.
module serial_word_receiver #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_receiver_if.slave bus
);
    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(WIDTH - 1);
    localparam int             FIRST_POS = (MSB_FIRST != 0) ? (WIDTH - 1) : 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] p_dout_r;
    logic             p_valid_r;
    logic             par_err_r;
    logic             overrun_r;
    logic             frame_err_r;

    logic [CW-1:0]    pos_s;
    logic [WIDTH-1:0] data_word_s;
    logic [WIDTH-1:0] first_word_s;
    logic [WIDTH-1:0] deliver_word_s;
    logic             deliver_s;
    logic             deliver_perr_s;
    logic             frame_event_s;
    logic             overrun_event_s;

    // Returns 1 when data plus its even-parity bit has an odd number of ones.
    function automatic logic parity_error(input logic [WIDTH-1:0] data, input logic pbit);
        return (^data) ^ pbit;
    endfunction

    // Next-word assembly, delivery qualification and error-event detection.
    always_comb begin
        pos_s        = (MSB_FIRST != 0) ? (LAST_CNT - cnt_r) : cnt_r;
        data_word_s  = shift_r;
        data_word_s[pos_s] = bus.s_din;
        first_word_s = '0;
        first_word_s[FIRST_POS] = bus.s_din;
        frame_event_s = bus.s_valid && bus.s_sync && (state_r != IDLE);
`ifdef SER_PARITY_EN
        deliver_s      = (state_r == PAR) && bus.s_valid && !bus.s_sync;
        deliver_word_s = shift_r;
        deliver_perr_s = parity_error(shift_r, bus.s_din);
`else
        deliver_s      = (state_r == SHIFT) && bus.s_valid && !bus.s_sync && (cnt_r == LAST_CNT);
        deliver_word_s = data_word_s;
        deliver_perr_s = 1'b0;
`endif
        // A completed word is only dropped when the held word is not being popped this edge.
        if (deliver_s && p_valid_r && !bus.p_ready) begin
            overrun_event_s = 1'b1;
        end else begin
            overrun_event_s = 1'b0;
        end
    end

    // Receive FSM, output holding register and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            shift_r     <= '0;
            p_dout_r    <= '0;
            p_valid_r   <= 1'b0;
            par_err_r   <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.s_valid && bus.s_sync) begin
                        shift_r <= first_word_s;
                        cnt_r   <= CW'(1);
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.s_valid) begin
                        if (bus.s_sync) begin
                            shift_r <= first_word_s;
                            cnt_r   <= CW'(1);
                            state_r <= SHIFT;
                        end else if (cnt_r == LAST_CNT) begin
                            shift_r <= data_word_s;
                            cnt_r   <= '0;
`ifdef SER_PARITY_EN
                            state_r <= PAR;
`else
                            state_r <= IDLE;
`endif
                        end else begin
                            shift_r <= data_word_s;
                            cnt_r   <= cnt_r + CW'(1);
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                PAR: begin
                    if (bus.s_valid) begin
                        if (bus.s_sync) begin
                            shift_r <= first_word_s;
                            cnt_r   <= CW'(1);
                            state_r <= SHIFT;
                        end else begin
                            cnt_r   <= '0;
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= PAR;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase

            if (deliver_s && !overrun_event_s) begin
                p_dout_r  <= deliver_word_s;
                p_valid_r <= 1'b1;
                par_err_r <= deliver_perr_s;
            end else if (p_valid_r && bus.p_ready) begin
                p_valid_r <= 1'b0;
            end else begin
                p_valid_r <= p_valid_r;
            end

            if (overrun_event_s) begin
                overrun_r <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            if (frame_event_s) begin
                frame_err_r <= 1'b1;
            end else if (bus.err_clr) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign bus.p_dout    = p_dout_r;
    assign bus.p_valid   = p_valid_r;
    assign bus.par_err   = par_err_r;
    assign bus.overrun   = overrun_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: one LSB-first and one MSB-first instance share a stream.
// Parity checks are enabled when SER_PARITY_EN is defined.
module tb_serial_word_receiver;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_word_receiver_if #(.WIDTH(4)) bus0 ();
    serial_word_receiver_if #(.WIDTH(4)) bus1 ();

    assign bus1.s_din   = bus0.s_din;
    assign bus1.s_valid = bus0.s_valid;
    assign bus1.s_sync  = bus0.s_sync;
    assign bus1.p_ready = bus0.p_ready;
    assign bus1.err_clr = bus0.err_clr;

    serial_word_receiver #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus0));
    serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus0.s_valid = 1'b0;
        bus0.s_sync  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic d, input logic sync);
        bus0.s_din   = d;
        bus0.s_valid = 1'b1;
        bus0.s_sync  = sync;
        @(posedge clk);
        #1;
        bus0.s_valid = 1'b0;
        bus0.s_sync  = 1'b0;
    endtask

    // v[k] is the k-th bit on the wire; a correct parity bit is appended when enabled.
    task automatic send_word(input logic [3:0] v, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_bit(v[k], (k == 0) ? 1'b1 : 1'b0);
            if (gap > 0 && k < 3) idle(gap);
        end
`ifdef SER_PARITY_EN
        send_bit(^v, 1'b0);
`endif
    endtask

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        n_checks     = 0;
        n_fail       = 0;
        bus0.s_din   = 1'b0;
        bus0.s_valid = 1'b0;
        bus0.s_sync  = 1'b0;
        bus0.p_ready = 1'b0;
        bus0.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p_valid", {7'd0, bus0.p_valid}, 8'd0);
        chk("rst_p_dout", {4'd0, bus0.p_dout}, 8'd0);
        chk("rst_overrun", {7'd0, bus0.overrun}, 8'd0);
        chk("rst_frame_err", {7'd0, bus0.frame_err}, 8'd0);
        chk("rst_par_err", {7'd0, bus0.par_err}, 8'd0);
        chk("rst_msb_p_valid", {7'd0, bus1.p_valid}, 8'd0);
        rst = 1'b0;

        // LSB-first stream 1,0,1,1
        bus0.p_ready = 1'b1;
        send_word(4'b1101, 0);
        chk("t1_p_valid", {7'd0, bus0.p_valid}, 8'd1);
        chk("t1_dout_lsb", {4'd0, bus0.p_dout}, 8'h0D);
        chk("t1_dout_msb", {4'd0, bus1.p_dout}, 8'h0B);
        idle(1);
        chk("t1_popped", {7'd0, bus0.p_valid}, 8'd0);

        // Stream 1,1,0,1 with s_valid gaps
        send_word(4'b1011, 1);
        chk("t2_p_valid", {7'd0, bus1.p_valid}, 8'd1);
        chk("t2_dout_msb", {4'd0, bus1.p_dout}, 8'h0D);
        chk("t2_dout_lsb", {4'd0, bus0.p_dout}, 8'h0B);
        idle(1);

        // Backpressure and overrun
        bus0.p_ready = 1'b0;
        send_word(4'b1010, 0);
        chk("t3_first_valid", {7'd0, bus0.p_valid}, 8'd1);
        chk("t3_no_overrun_yet", {7'd0, bus0.overrun}, 8'd0);
        send_word(4'b0101, 0);
        chk("t3_kept_lsb", {4'd0, bus0.p_dout}, 8'h0A);
        chk("t3_kept_msb", {4'd0, bus1.p_dout}, 8'h05);
        chk("t3_overrun", {7'd0, bus0.overrun}, 8'd1);
        chk("t3_overrun_msb", {7'd0, bus1.overrun}, 8'd1);
        idle(2);
        chk("t3_held_valid", {7'd0, bus0.p_valid}, 8'd1);
        chk("t3_held_dout", {4'd0, bus0.p_dout}, 8'h0A);
        bus0.p_ready = 1'b1;
        idle(1);
        chk("t3_pop", {7'd0, bus0.p_valid}, 8'd0);
        chk("t3_overrun_sticky", {7'd0, bus0.overrun}, 8'd1);
        bus0.err_clr = 1'b1;
        idle(1);
        bus0.err_clr = 1'b0;
        chk("t3_overrun_clr", {7'd0, bus0.overrun}, 8'd0);

        // Resync: partial word 1,0 then a full word 0,1,1,0
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        chk("t4_no_frame_yet", {7'd0, bus0.frame_err}, 8'd0);
        chk("t4_no_word_yet", {7'd0, bus0.p_valid}, 8'd0);
        send_word(4'b0110, 0);
        chk("t4_frame_err", {7'd0, bus0.frame_err}, 8'd1);
        chk("t4_p_valid", {7'd0, bus0.p_valid}, 8'd1);
        chk("t4_dout_lsb", {4'd0, bus0.p_dout}, 8'h06);
        chk("t4_dout_msb", {4'd0, bus1.p_dout}, 8'h06);
        idle(1);
        chk("t4_single_word", {7'd0, bus0.p_valid}, 8'd0);

        // Reset mid-word with a held word and frame_err still set
        bus0.p_ready = 1'b0;
        send_word(4'b0011, 0);
        chk("t5_held_before_rst", {7'd0, bus0.p_valid}, 8'd1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_p_valid", {7'd0, bus0.p_valid}, 8'd0);
        chk("t5_rst_p_dout", {4'd0, bus0.p_dout}, 8'd0);
        chk("t5_rst_frame_err", {7'd0, bus0.frame_err}, 8'd0);
        chk("t5_rst_overrun", {7'd0, bus0.overrun}, 8'd0);
        chk("t5_rst_par_err", {7'd0, bus0.par_err}, 8'd0);
        #1;
        rst = 1'b0;
        bus0.p_ready = 1'b1;
        send_word(4'b1001, 0);
        chk("t5_p_valid", {7'd0, bus0.p_valid}, 8'd1);
        chk("t5_dout_lsb", {4'd0, bus0.p_dout}, 8'h09);
        chk("t5_dout_msb", {4'd0, bus1.p_dout}, 8'h09);
        chk("t5_frame_clean", {7'd0, bus0.frame_err}, 8'd0);
        idle(1);

`ifdef SER_PARITY_EN
        // Data 1,1,0,1 with correct then wrong parity bit
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("t6_not_on_data", {7'd0, bus0.p_valid}, 8'd0);
        send_bit(1'b1, 1'b0);
        chk("t6_p_valid", {7'd0, bus0.p_valid}, 8'd1);
        chk("t6_dout_lsb", {4'd0, bus0.p_dout}, 8'h0B);
        chk("t6_dout_msb", {4'd0, bus1.p_dout}, 8'h0D);
        chk("t6_par_ok", {7'd0, bus0.par_err}, 8'd0);
        idle(1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("t6_par_bad", {7'd0, bus0.par_err}, 8'd1);
        chk("t6_par_bad_msb", {7'd0, bus1.par_err}, 8'd1);
        idle(1);
`else
        // Odd-weight data: par_err stays 0 without the parity feature
        send_word(4'b0111, 0);
        chk("t6_valid_on_last", {7'd0, bus0.p_valid}, 8'd1);
        chk("t6_par_err_tied", {7'd0, bus0.par_err}, 8'd0);
        idle(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
